trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port commit_valid  input  1  commit_inst/commit_pc describe a committing instruction.
REQ-004 SHALL have port commit_inst  input  32  committing instruction word.
REQ-005 SHALL have port commit_pc  input  64  address of committing instruction.
REQ-006 SHALL have port hold  input  1  memory/MMU stall; freezes all state when 1.
REQ-007 SHALL have port csr_we  input  1  CSR write strobe.
REQ-008 SHALL have port csr_addr  input  12  CSR address for read and write.
REQ-009 SHALL have port csr_wdata  input  64  CSR write data.
REQ-010 SHALL have port csr_rdata  output  64  combinational read of CSR at csr_addr.
REQ-011 SHALL have ports mtvec_data, mepc_data, stvec_data, sepc_data  output  64 each  current CSR values for PC redirect.
REQ-012 SHALL have ports set_pc_to_mepc, set_pc_to_sepc  output  1 each  registered one-cycle redirect pulses.
REQ-013 SHALL have port trap_busy  output  1  high while FSM is not IDLE.
REQ-014 SHALL have port priv  output  2  current privilege (00 U, 01 S, 11 M).

Function
REQ-015 SHALL decode: ECALL=0x00000073, UNIMP=0xC0001073, MRET=0x30200073, SRET=0x10200073; any other word is non-trap.
REQ-016 SHALL implement CSRs: mstatus 0x300, medeleg 0x302, mtvec 0x305, mepc 0x341, mcause 0x342, stvec 0x105, sepc 0x141, scause 0x142; other addresses read 0, writes ignored.
REQ-017 SHALL force bits [1:0] of mtvec, stvec, mepc, sepc to 0 on any write.
REQ-018 SHALL use mstatus[12:11] as MPP and mstatus[8] as SPP; other mstatus bits plain read/write storage.
REQ-019 SHALL implement FSM states IDLE, RET_M, RET_S; trap entry completes in one cycle from IDLE.
REQ-020 SHALL, in IDLE with commit_valid=1 and hold=0 on ECALL, take cause = 8 for U, 9 for S, 11 for M; on UNIMP, cause = 2.
REQ-021 SHALL delegate to S when priv!=M and medeleg[cause]=1: next edge sepc<=commit_pc, scause<=cause, SPP<=(priv==S), priv<=S.
REQ-022 SHALL otherwise trap to M: next edge mepc<=commit_pc, mcause<=cause, MPP<=priv, priv<=M.
REQ-023 SHALL, in IDLE on committed MRET: next edge state<=RET_M, priv<=MPP, MPP<=00; set_pc_to_mepc=1 for the whole RET_M cycle.
REQ-024 SHALL, in IDLE on committed SRET: next edge state<=RET_S, priv<=(SPP?S:U), SPP<=0; set_pc_to_sepc=1 for the whole RET_S cycle.
REQ-025 SHALL return RET_M/RET_S to IDLE after one cycle with hold=0; while hold=1, state and pulse stay unchanged.
REQ-026 SHALL ignore commits arriving while not IDLE or while hold=1.
REQ-027 SHALL never assert set_pc_to_mepc and set_pc_to_sepc in the same cycle.
REQ-028 SHALL, when csr_we and a trap/return update the same CSR in one cycle, let the trap/return update win; other CSRs take the csr write.
REQ-029 SHALL apply csr writes only when hold=0; reads are unaffected by hold.
REQ-030 SHALL drive mtvec_data etc. directly from the registers (new values visible the cycle after write).

Reset
REQ-031 SHALL on rst clear all CSRs to 0, set priv=11, state=IDLE, both pulses and trap_busy to 0, immediately and independent of clk.
REQ-032 SHALL, on rst asserted mid-RET_M/RET_S, drop the pulse that same instant and discard the pending return.

Verification
REQ-033 SHALL test: priv=M, ECALL at pc 0x80000010 -> next cycle mepc=0x80000010, mcause=11, MPP=11, priv=11, no pulse.
REQ-034 SHALL test: MPP=00, MRET committed -> set_pc_to_mepc high exactly one cycle, priv=00, MPP=00, trap_busy high that cycle.
REQ-035 SHALL test: priv=U, medeleg=0x100, ECALL at 0x1000 -> sepc=0x1000, scause=8, SPP=0, priv=01; then SRET -> set_pc_to_sepc one cycle, priv=00.
REQ-036 SHALL test: write mtvec=0x80000103 -> reads 0x80000100; csr_we to mepc same cycle as ECALL -> mepc=commit_pc.
REQ-037 SHALL test: MRET with hold=1 for 3 cycles during RET_M -> pulse held 4 cycles total; commits during RET_M ignored.
REQ-038 SHALL test: rst asserted during RET_S -> pulse low asynchronously, priv=11, all CSRs 0.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: privilege, trap entry and trap return control with the trap CSRs.
//
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   commit_valid/inst/pc        committing instruction (ECALL, UNIMP, MRET, SRET decoded)
//   hold                        stall; freezes all state while high
//   csr_we/addr/wdata           CSR write port (applied only when hold is low)
//   csr_rdata                   combinational read of the CSR at csr_addr
//   mtvec/mepc/stvec/sepc_data  live CSR values for PC redirect
//   set_pc_to_mepc/sepc         redirect pulses, high for the whole RET_M / RET_S cycle
//   trap_busy                   FSM not idle
//   priv                        current privilege (00 U, 01 S, 11 M)
module trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [31:0] commit_inst,
    input  logic [63:0] commit_pc,
    input  logic        hold,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [63:0] csr_wdata,
    output logic [63:0] csr_rdata,
    output logic [63:0] mtvec_data,
    output logic [63:0] mepc_data,
    output logic [63:0] stvec_data,
    output logic [63:0] sepc_data,
    output logic        set_pc_to_mepc,
    output logic        set_pc_to_sepc,
    output logic        trap_busy,
    output logic [1:0]  priv
);

    localparam logic [31:0] InstEcall = 32'h0000_0073;
    localparam logic [31:0] InstUnimp = 32'hC000_1073;
    localparam logic [31:0] InstMret  = 32'h3020_0073;
    localparam logic [31:0] InstSret  = 32'h1020_0073;

    localparam logic [11:0] AddrMstatus = 12'h300;
    localparam logic [11:0] AddrMedeleg = 12'h302;
    localparam logic [11:0] AddrMtvec   = 12'h305;
    localparam logic [11:0] AddrMepc    = 12'h341;
    localparam logic [11:0] AddrMcause  = 12'h342;
    localparam logic [11:0] AddrStvec   = 12'h105;
    localparam logic [11:0] AddrSepc    = 12'h141;
    localparam logic [11:0] AddrScause  = 12'h142;

    localparam logic [1:0] PrivU = 2'b00;
    localparam logic [1:0] PrivS = 2'b01;
    localparam logic [1:0] PrivM = 2'b11;

    typedef enum logic [1:0] {StIdle, StRetM, StRetS} state_e;

    state_e      state_q, state_d;
    logic [1:0]  priv_q, priv_d;
    logic [63:0] mstatus_q, mstatus_d;
    logic [63:0] medeleg_q, medeleg_d;
    logic [63:0] mtvec_q, mtvec_d;
    logic [63:0] mepc_q, mepc_d;
    logic [63:0] mcause_q, mcause_d;
    logic [63:0] stvec_q, stvec_d;
    logic [63:0] sepc_q, sepc_d;
    logic [63:0] scause_q, scause_d;

    logic        accept;
    logic        is_ecall, is_unimp, is_mret, is_sret;
    logic [5:0]  cause;

    assign is_ecall = (commit_inst == InstEcall);
    assign is_unimp = (commit_inst == InstUnimp);
    assign is_mret  = (commit_inst == InstMret);
    assign is_sret  = (commit_inst == InstSret);
    assign accept   = (state_q == StIdle) && commit_valid && !hold;

    always_comb begin
        cause = 6'd2;
        if (is_ecall) begin
            unique case (priv_q)
                PrivU:   cause = 6'd8;
                PrivS:   cause = 6'd9;
                default: cause = 6'd11;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        priv_d    = priv_q;
        mstatus_d = mstatus_q;
        medeleg_d = medeleg_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        stvec_d   = stvec_q;
        sepc_d    = sepc_q;
        scause_d  = scause_q;

        // Software writes first so a same-cycle trap/return update overrides them.
        if (csr_we && !hold) begin
            case (csr_addr)
                AddrMstatus: mstatus_d = csr_wdata;
                AddrMedeleg: medeleg_d = csr_wdata;
                AddrMtvec:   mtvec_d   = {csr_wdata[63:2], 2'b00};
                AddrMepc:    mepc_d    = {csr_wdata[63:2], 2'b00};
                AddrMcause:  mcause_d  = csr_wdata;
                AddrStvec:   stvec_d   = {csr_wdata[63:2], 2'b00};
                AddrSepc:    sepc_d    = {csr_wdata[63:2], 2'b00};
                AddrScause:  scause_d  = csr_wdata;
                default: ;
            endcase
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_ecall || is_unimp) begin
                        if (priv_q != PrivM && medeleg_q[cause]) begin
                            sepc_d       = commit_pc;
                            scause_d     = {58'd0, cause};
                            mstatus_d[8] = (priv_q == PrivS);
                            priv_d       = PrivS;
                        end else begin
                            mepc_d           = commit_pc;
                            mcause_d         = {58'd0, cause};
                            mstatus_d[12:11] = priv_q;
                            priv_d           = PrivM;
                        end
                    end else if (is_mret) begin
                        state_d          = StRetM;
                        priv_d           = mstatus_q[12:11];
                        mstatus_d[12:11] = PrivU;
                    end else if (is_sret) begin
                        state_d      = StRetS;
                        priv_d       = mstatus_q[8] ? PrivS : PrivU;
                        mstatus_d[8] = 1'b0;
                    end
                end
            end
            StRetM, StRetS: begin
                if (!hold) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            priv_q    <= PrivM;
            mstatus_q <= '0;
            medeleg_q <= '0;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            stvec_q   <= '0;
            sepc_q    <= '0;
            scause_q  <= '0;
        end else begin
            state_q   <= state_d;
            priv_q    <= priv_d;
            mstatus_q <= mstatus_d;
            medeleg_q <= medeleg_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            stvec_q   <= stvec_d;
            sepc_q    <= sepc_d;
            scause_q  <= scause_d;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            AddrMstatus: csr_rdata = mstatus_q;
            AddrMedeleg: csr_rdata = medeleg_q;
            AddrMtvec:   csr_rdata = mtvec_q;
            AddrMepc:    csr_rdata = mepc_q;
            AddrMcause:  csr_rdata = mcause_q;
            AddrStvec:   csr_rdata = stvec_q;
            AddrSepc:    csr_rdata = sepc_q;
            AddrScause:  csr_rdata = scause_q;
            default:     csr_rdata = '0;
        endcase
    end

    // Pulses decode straight from the state flop: one per return state, so they are
    // mutually exclusive and drop the instant reset clears the state.
    assign set_pc_to_mepc = (state_q == StRetM);
    assign set_pc_to_sepc = (state_q == StRetS);
    assign trap_busy      = (state_q != StIdle);
    assign priv           = priv_q;
    assign mtvec_data     = mtvec_q;
    assign mepc_data      = mepc_q;
    assign stvec_data     = stvec_q;
    assign sepc_data      = sepc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_inst;
    logic [63:0] commit_pc;
    logic        hold;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic [63:0] mtvec_data, mepc_data, stvec_data, sepc_data;
    logic        set_pc_to_mepc, set_pc_to_sepc, trap_busy;
    logic [1:0]  priv;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [63:0] rd;

    localparam logic [31:0] Ecall = 32'h0000_0073;
    localparam logic [31:0] Unimp = 32'hC000_1073;
    localparam logic [31:0] Mret  = 32'h3020_0073;
    localparam logic [31:0] Sret  = 32'h1020_0073;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_inst    (commit_inst),
        .commit_pc      (commit_pc),
        .hold           (hold),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .mtvec_data     (mtvec_data),
        .mepc_data      (mepc_data),
        .stvec_data     (stvec_data),
        .sepc_data      (sepc_data),
        .set_pc_to_mepc (set_pc_to_mepc),
        .set_pc_to_sepc (set_pc_to_sepc),
        .trap_busy      (trap_busy),
        .priv           (priv)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] inst, input logic [63:0] pc);
        commit_valid = 1'b1;
        commit_inst  = inst;
        commit_pc    = pc;
        tick();
        commit_valid = 1'b0;
        commit_inst  = '0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic csr_read(input logic [11:0] a, output logic [63:0] d);
        csr_addr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic check_all_csr_zero(input string tag);
        logic [11:0] addrs [8];
        addrs = '{12'h300, 12'h302, 12'h305, 12'h341, 12'h342, 12'h105, 12'h141, 12'h142};
        for (int i = 0; i < 8; i++) begin
            csr_read(addrs[i], rd);
            check_val($sformatf("%s csr 0x%0h", tag, addrs[i]), rd, 64'h0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        commit_valid = 1'b0;
        commit_inst  = '0;
        commit_pc    = '0;
        hold         = 1'b0;
        csr_we       = 1'b0;
        csr_addr     = '0;
        csr_wdata    = '0;
        #2;
        check_val("reset priv", 64'(priv), 64'h3);
        check_val("reset busy", 64'(trap_busy), 64'h0);
        check_val("reset pulse m", 64'(set_pc_to_mepc), 64'h0);
        check_val("reset pulse s", 64'(set_pc_to_sepc), 64'h0);
        check_all_csr_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // ECALL from M
        commit(Ecall, 64'h8000_0010);
        check_val("ecall_m mepc", mepc_data, 64'h8000_0010);
        csr_read(12'h342, rd);
        check_val("ecall_m mcause", rd, 64'd11);
        csr_read(12'h300, rd);
        check_val("ecall_m mpp", 64'(rd[12:11]), 64'h3);
        check_val("ecall_m priv", 64'(priv), 64'h3);
        check_val("ecall_m no pulse", 64'({set_pc_to_mepc, set_pc_to_sepc}), 64'h0);

        // MRET with MPP=00
        csr_write(12'h300, 64'h0);
        commit(Mret, 64'h8000_0020);
        check_val("mret pulse", 64'(set_pc_to_mepc), 64'h1);
        check_val("mret no s pulse", 64'(set_pc_to_sepc), 64'h0);
        check_val("mret busy", 64'(trap_busy), 64'h1);
        check_val("mret priv", 64'(priv), 64'h0);
        csr_read(12'h300, rd);
        check_val("mret mpp", 64'(rd[12:11]), 64'h0);
        tick();
        check_val("mret pulse end", 64'(set_pc_to_mepc), 64'h0);
        check_val("mret busy end", 64'(trap_busy), 64'h0);

        // Delegated ECALL from U, then SRET
        csr_write(12'h302, 64'h100);
        commit(Ecall, 64'h1000);
        check_val("deleg sepc", sepc_data, 64'h1000);
        csr_read(12'h142, rd);
        check_val("deleg scause", rd, 64'd8);
        csr_read(12'h300, rd);
        check_val("deleg spp", 64'(rd[8]), 64'h0);
        check_val("deleg priv", 64'(priv), 64'h1);
        check_val("deleg mepc untouched", mepc_data, 64'h8000_0010);
        commit(Sret, 64'h1004);
        check_val("sret pulse", 64'(set_pc_to_sepc), 64'h1);
        check_val("sret no m pulse", 64'(set_pc_to_mepc), 64'h0);
        check_val("sret priv", 64'(priv), 64'h0);
        tick();
        check_val("sret pulse end", 64'(set_pc_to_sepc), 64'h0);

        // mtvec low-bit masking; csr write to mepc colliding with a trap
        csr_write(12'h305, 64'h8000_0103);
        csr_read(12'h305, rd);
        check_val("mtvec mask read", rd, 64'h8000_0100);
        check_val("mtvec data", mtvec_data, 64'h8000_0100);
        csr_we       = 1'b1;
        csr_addr     = 12'h341;
        csr_wdata    = 64'h5550;
        commit(Unimp, 64'h2000);
        csr_we       = 1'b0;
        check_val("collide mepc", mepc_data, 64'h2000);
        csr_read(12'h342, rd);
        check_val("unimp mcause", rd, 64'd2);
        csr_read(12'h300, rd);
        check_val("unimp mpp", 64'(rd[12:11]), 64'h0);
        check_val("unimp priv", 64'(priv), 64'h3);

        // MRET stretched by hold; commits and csr writes during RET_M ignored
        commit(Mret, 64'h2004);
        commit_valid = 1'b1;
        commit_inst  = Ecall;
        commit_pc    = 64'h3000;
        csr_we       = 1'b1;
        csr_addr     = 12'h105;
        csr_wdata    = 64'h40;
        hold         = 1'b1;
        check_val("hold pulse c1", 64'(set_pc_to_mepc), 64'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("hold pulse c%0d", i + 2), 64'(set_pc_to_mepc), 64'h1);
        end
        check_val("hold stvec frozen", stvec_data, 64'h0);
        hold   = 1'b0;
        csr_we = 1'b0;
        tick();
        commit_valid = 1'b0;
        check_val("hold pulse end", 64'(set_pc_to_mepc), 64'h0);
        check_val("hold commit ignored priv", 64'(priv), 64'h0);
        check_val("hold commit ignored mepc", mepc_data, 64'h2000);

        // Async reset in the middle of RET_S
        commit(Sret, 64'h2008);
        check_val("pre-rst pulse", 64'(set_pc_to_sepc), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst pulse drop", 64'(set_pc_to_sepc), 64'h0);
        check_val("rst busy", 64'(trap_busy), 64'h0);
        check_val("rst priv", 64'(priv), 64'h3);
        check_all_csr_zero("rst mid-ret");
        tick();
        rst = 1'b0;
        tick();
        check_val("post-rst pulse", 64'(set_pc_to_sepc), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
